// File: rtl/rob_ctrl_pkg.sv
// Shared configuration for the reorder-buffer controller:
// sizing defaults and the controller's FSM state encoding.
package rob_ctrl_pkg;

  localparam int ROBSize     = 16;
  localparam int ROBIdxWidth = 4;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_WAIT_STORE = 2'd1,
    S_FLUSH      = 2'd2
  } rob_state_e;

endpackage

// File: rtl/rob_ctrl_if.sv
// Issue/writeback/commit signal bundle around the ROB controller.
// master drives the ROB inputs; slave is the ROB side.
interface rob_ctrl_if #(
  parameter int IDX_W = rob_ctrl_pkg::ROBIdxWidth
);

  logic             rdy_in;
  logic             alloc_en_in;
  logic             alloc_store_in;
  logic             wb_en_in;
  logic [IDX_W-1:0] wb_idx_in;
  logic             wb_mispredict_in;
  logic             store_ack_in;
  logic [IDX_W-1:0] rob_head_out;
  logic [IDX_W-1:0] rob_tail_out;
  logic             rob_empty_out;
  logic             rob_full_out;
  logic             commit_en_out;
  logic [IDX_W-1:0] commit_idx_out;
  logic             store_commit_out;
  logic             flush_out;

  modport master (
    output rdy_in, alloc_en_in, alloc_store_in,
    output wb_en_in, wb_idx_in, wb_mispredict_in,
    output store_ack_in,
    input  rob_head_out, rob_tail_out,
    input  rob_empty_out, rob_full_out,
    input  commit_en_out, commit_idx_out,
    input  store_commit_out, flush_out
  );

  modport slave (
    input  rdy_in, alloc_en_in, alloc_store_in,
    input  wb_en_in, wb_idx_in, wb_mispredict_in,
    input  store_ack_in,
    output rob_head_out, rob_tail_out,
    output rob_empty_out, rob_full_out,
    output commit_en_out, commit_idx_out,
    output store_commit_out, flush_out
  );

endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocation and retirement,
// store handshake with the LSB, and flush on mispredicted branch.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = ROBSize,
  parameter int IDX_W    = ROBIdxWidth
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_en_in,
  input  logic             alloc_store_in,
  input  logic             wb_en_in,
  input  logic [IDX_W-1:0] wb_idx_in,
  input  logic             wb_mispredict_in,
  input  logic             store_ack_in,
  output logic [IDX_W-1:0] rob_head_out,
  output logic [IDX_W-1:0] rob_tail_out,
  output logic             rob_empty_out,
  output logic             rob_full_out,
  output logic             commit_en_out,
  output logic [IDX_W-1:0] commit_idx_out,
  output logic             store_commit_out,
  output logic             flush_out
);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  localparam idx_t IDX_LAST = idx_t'(ROB_SIZE - 1);
  localparam cnt_t CNT_FULL = cnt_t'(ROB_SIZE);

  rob_state_e          r_state;
  idx_t                r_head;
  idx_t                r_tail;
  cnt_t                r_count;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_store;
  logic [ROB_SIZE-1:0] r_mispred;
  logic                r_empty;
  logic                r_full;
  logic                r_commit_en;
  idx_t                r_commit_idx;
  logic                r_store_commit;
  logic                r_flush;

  logic w_hd_rdy;
  logic w_retire;
  logic w_alloc;
  idx_t w_head_nx;
  idx_t w_tail_nx;
  cnt_t w_cnt_nx;

  assign w_hd_rdy = (r_state == S_RUN) && (r_count != '0)
                  && r_ready[r_head];

  // A store at head retires only on the LSB ack, never straight from RUN.
  assign w_retire = (w_hd_rdy && !r_store[r_head])
                  || ((r_state == S_WAIT_STORE) && store_ack_in);

  assign w_alloc = alloc_en_in && (r_state != S_FLUSH)
                 && ((r_count != CNT_FULL) || w_retire);

  assign w_head_nx = (r_head == IDX_LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nx = (r_tail == IDX_LAST) ? '0 : r_tail + 1'b1;
  assign w_cnt_nx  = r_count + cnt_t'(w_alloc) - cnt_t'(w_retire);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= S_RUN;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_ready        <= '0;
      r_store        <= '0;
      r_mispred      <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_commit_en    <= 1'b0;
      r_commit_idx   <= '0;
      r_store_commit <= 1'b0;
      r_flush        <= 1'b0;
    end else if (!rdy_in) begin
      r_commit_en <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_commit_en <= 1'b0;
      r_flush     <= 1'b0;
      if (wb_en_in) begin
        r_ready[wb_idx_in]   <= 1'b1;
        r_mispred[wb_idx_in] <= wb_mispredict_in;
      end
      if (w_alloc) begin
        r_ready[r_tail]   <= 1'b0;
        r_mispred[r_tail] <= 1'b0;
        r_store[r_tail]   <= alloc_store_in;
        r_tail            <= w_tail_nx;
      end
      if (w_retire) begin
        r_commit_en  <= 1'b1;
        r_commit_idx <= r_head;
        r_head       <= w_head_nx;
      end
      r_count <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == CNT_FULL);
      unique case (r_state)
        S_RUN: begin
          if (w_hd_rdy && r_store[r_head]) begin
            r_state        <= S_WAIT_STORE;
            r_store_commit <= 1'b1;
            r_commit_idx   <= r_head;
          end else if (w_hd_rdy && r_mispred[r_head]) begin
            r_state <= S_FLUSH;
          end
        end
        S_WAIT_STORE: begin
          if (store_ack_in) begin
            r_store_commit <= 1'b0;
            r_state        <= S_RUN;
          end
        end
        S_FLUSH: begin
          r_flush   <= 1'b1;
          r_head    <= '0;
          r_tail    <= '0;
          r_count   <= '0;
          r_ready   <= '0;
          r_store   <= '0;
          r_mispred <= '0;
          r_empty   <= 1'b1;
          r_full    <= 1'b0;
          r_state   <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign rob_head_out     = r_head;
  assign rob_tail_out     = r_tail;
  assign rob_empty_out    = r_empty;
  assign rob_full_out     = r_full;
  assign commit_en_out    = r_commit_en;
  assign commit_idx_out   = r_commit_idx;
  assign store_commit_out = r_store_commit;
  assign flush_out        = r_flush;

endmodule
